// File: rtl/cap_axi_burst_writer.sv
// AXI4 write-burst engine: drains an FWFT pixel FIFO into a ring of NUM_BUF frame buffers, one burst in flight.
// Optional BRESP error counter enabled by defining CAPW_BRESP_ERR_EN.
// Valid/ready: a transfer happens on a rising ACLK edge where both valid and ready are high; once raised, valid and its payload hold until that edge.
module cap_axi_burst_writer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BUF    = 2,
  parameter int FIFO_CNT_W = 11,
  parameter int FRAME_W    = 20
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  ENABLE,
  input  logic                  START,
  input  logic [ADDR_W-1:0]     BASE_ADDR,
  input  logic [ADDR_W-1:0]     BUF_SIZE,
  input  logic [FRAME_W-1:0]    FRAME_BEATS,
  input  logic [DATA_W-1:0]     FIFO_DOUT,
  input  logic [FIFO_CNT_W-1:0] FIFO_CNT,
  output logic                  FIFO_RD,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [7:0]            AWLEN,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic                  WLAST,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic [2:0]            CUR_BUF,
  output logic [7:0]            ERR_CNT
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0]     BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [FIFO_CNT_W-1:0] BL_CNT      = FIFO_CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0]            LAST_BUF    = 3'(NUM_BUF - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   bursts_q, bursts_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [2:0]           buf_q, buf_d;
  logic                 cnt_ok_q, cnt_ok_d;

  logic [FRAME_W-1:0]   frame_bursts;
  logic                 accept_start;
  logic                 aw_hs, w_hs, b_hs, last_burst;

  assign frame_bursts = FRAME_BEATS >> BEAT_W;
  assign accept_start = (state_q == S_IDLE) && START && ENABLE && (frame_bursts != '0);
  assign aw_hs        = AWVALID && AWREADY;
  assign w_hs         = WVALID && WREADY;
  assign b_hs         = BREADY && BVALID;
  assign last_burst   = (bursts_q == FRAME_W'(1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      bursts_q <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
      buf_q    <= '0;
      cnt_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bursts_q <= bursts_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      buf_q    <= buf_d;
      cnt_ok_q <= cnt_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_start) state_d = S_ADDR;
      S_ADDR: if (aw_hs) state_d = S_DATA;
      S_DATA: if (w_hs && WLAST) state_d = S_RESP;
      S_RESP: begin
        if (b_hs) begin
          if (last_burst || !ENABLE) state_d = S_IDLE;
          else                       state_d = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    WLAST      = 1'b0;
    BREADY     = 1'b0;
    FRAME_DONE = 1'b0;
    BUSY       = (state_q != S_IDLE);
    case (state_q)
      S_ADDR: AWVALID = cnt_ok_q;
      S_DATA: begin
        WVALID = 1'b1;
        WLAST  = (beat_q == LAST_BEAT);
      end
      S_RESP: begin
        BREADY     = 1'b1;
        FRAME_DONE = BVALID && last_burst;
      end
      default: ;
    endcase
  end

  // Once AWVALID is up it must not drop before AWREADY, so the FIFO-level check is held while waiting.
  always_comb begin
    bursts_d = bursts_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    cnt_ok_d = (FIFO_CNT >= BL_CNT) || (AWVALID && !AWREADY);
    if (accept_start) begin
      bursts_d = frame_bursts;
      addr_d   = BASE_ADDR + ADDR_W'(buf_q) * BUF_SIZE;
    end
    if (aw_hs) beat_d = '0;
    if (w_hs)  beat_d = beat_q + BEAT_W'(1);
    if (b_hs) begin
      bursts_d = bursts_q - FRAME_W'(1);
      addr_d   = addr_q + BURST_BYTES;
      if (last_burst) buf_d = (buf_q == LAST_BUF) ? 3'd0 : buf_q + 3'd1;
    end
  end

`ifdef CAPW_BRESP_ERR_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept_start)
      err_d = '0;
    else if (b_hs && (BRESP != 2'b00) && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) err_q <= '0;
    else          err_q <= err_d;
  end

  assign ERR_CNT = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^BRESP;
  assign ERR_CNT      = '0;
`endif

  assign FIFO_RD = w_hs;
  assign WDATA   = FIFO_DOUT;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'(BURST_LEN - 1);
  assign CUR_BUF = buf_q;

endmodule

// File: tb/tb_cap_axi_burst_writer.sv
// Bench for cap_axi_burst_writer: FIFO model, AXI slave responder, scoreboard monitor on AW/W/B traffic.
// ERR_CNT expectation follows CAPW_BRESP_ERR_EN.
module tb_cap_axi_burst_writer;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 32;
  localparam int BURST_LEN  = 16;
  localparam int NUM_BUF    = 2;
  localparam int FIFO_CNT_W = 11;
  localparam int FRAME_W    = 20;
  localparam logic [ADDR_W-1:0] BASE = 32'h2000_0000;

  logic                  ACLK = 1'b0;
  logic                  ARESETN;
  logic                  ENABLE, START;
  logic [ADDR_W-1:0]     BASE_ADDR, BUF_SIZE;
  logic [FRAME_W-1:0]    FRAME_BEATS;
  logic [DATA_W-1:0]     FIFO_DOUT;
  logic [FIFO_CNT_W-1:0] FIFO_CNT;
  logic                  FIFO_RD;
  logic [ADDR_W-1:0]     AWADDR;
  logic [7:0]            AWLEN;
  logic                  AWVALID, AWREADY;
  logic [DATA_W-1:0]     WDATA;
  logic                  WVALID, WREADY, WLAST;
  logic [1:0]            BRESP;
  logic                  BVALID, BREADY;
  logic                  BUSY, FRAME_DONE;
  logic [2:0]            CUR_BUF;
  logic [7:0]            ERR_CNT;

  cap_axi_burst_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .NUM_BUF(NUM_BUF), .FIFO_CNT_W(FIFO_CNT_W), .FRAME_W(FRAME_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .START(START),
    .BASE_ADDR(BASE_ADDR), .BUF_SIZE(BUF_SIZE), .FRAME_BEATS(FRAME_BEATS),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_CNT(FIFO_CNT), .FIFO_RD(FIFO_RD),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CUR_BUF(CUR_BUF), .ERR_CNT(ERR_CNT)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_aw_q[$];
  logic [DATA_W-1:0] exp_w_q[$];
  logic [1:0]        bresp_q[$];

  int aw_hs_cnt      = 0;
  int frame_done_cnt = 0;
  int wlast_cnt      = 0;
  int aw_delay       = 0;
  bit w_random       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // ---------------- FIFO model ----------------
  logic [DATA_W-1:0] fifo_mem [0:1023];
  logic [31:0] wr_cnt = 0;
  logic [31:0] rd_cnt = 0;
  logic [31:0] seq    = 0;

  assign FIFO_DOUT = fifo_mem[rd_cnt[9:0]];
  assign FIFO_CNT  = FIFO_CNT_W'(wr_cnt - rd_cnt);

  always @(posedge ACLK) if (FIFO_RD) rd_cnt <= rd_cnt + 1;

  // ---------------- driver tasks ----------------
  task automatic push_words(input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {32'hC0DE_0000 | seq, ~seq};
      fifo_mem[wr_cnt[9:0]] = w;
      exp_w_q.push_back(w);
      wr_cnt = wr_cnt + 1;
      seq    = seq + 1;
    end
  endtask

  task automatic expect_bursts(input logic [ADDR_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_aw_q.push_back(base + ADDR_W'(i * 128));
  endtask

  task automatic pulse_start(input int beats);
    @(posedge ACLK); #1;
    FRAME_BEATS = FRAME_W'(beats);
    START = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge ACLK);
    while (BUSY && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_idle"}, BUSY, 1'b0);
  endtask

  // ---------------- AXI slave responder ----------------
  initial begin
    int aw_wait = 0;
    int b_wait  = 0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    forever begin
      @(posedge ACLK); #1;
      if (AWREADY) begin
        AWREADY = 1'b0;
        aw_wait = 0;
      end else if (AWVALID) begin
        if (aw_wait >= aw_delay) AWREADY = 1'b1;
        else aw_wait++;
      end
      WREADY = w_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (BVALID) begin
        BVALID = 1'b0;
        BRESP  = 2'b00;
      end else if (BREADY) begin
        b_wait++;
        if (b_wait >= 2) begin
          BVALID = 1'b1;
          BRESP  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          b_wait = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit                aw_done = 0;
  bit                aw_wait_prev = 0;
  bit                fd_prev = 0;
  int                w_beat = 0;
  logic [ADDR_W-1:0] aw_prev_addr;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      aw_done = 0; aw_wait_prev = 0; fd_prev = 0; w_beat = 0;
    end else begin
      if (aw_wait_prev) begin
        check("aw_hold_valid", AWVALID, 1'b1);
        check("aw_hold_addr", AWADDR, aw_prev_addr);
      end
      aw_wait_prev = AWVALID && !AWREADY;
      aw_prev_addr = AWADDR;
      if (AWVALID && AWREADY) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else check("awaddr", AWADDR, exp_aw_q.pop_front());
        check("awlen", AWLEN, 8'd15);
        aw_done = 1;
        aw_hs_cnt++;
      end
      if (WVALID && !aw_done) fail_now("w_before_aw");
      if (WVALID) check("fifo_rd", FIFO_RD, WREADY);
      if (WVALID && WREADY) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else check("wdata", WDATA, exp_w_q.pop_front());
        check("wlast", WLAST, (w_beat == BURST_LEN - 1));
        if (WLAST) begin
          aw_done = 0;
          wlast_cnt++;
        end
        w_beat = (w_beat + 1) % BURST_LEN;
      end
      if (FRAME_DONE) begin
        if (fd_prev) fail_now("frame_done_width");
        frame_done_cnt++;
      end
      fd_prev = FRAME_DONE;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_done;
    int rd0, wl0, hs0, n;
    bit seen_aw;
    logic [2:0] t2_buf [3];
    logic [ADDR_W-1:0] t2_base [3];
    t2_base = '{32'h2000_0000, 32'h2000_1000, 32'h2000_0000};
    t2_buf  = '{3'd1, 3'd0, 3'd1};

    ARESETN = 1'b0; ENABLE = 1'b1; START = 1'b0;
    BASE_ADDR = BASE; BUF_SIZE = 32'h1000; FRAME_BEATS = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    check("rst_cur_buf", CUR_BUF, 3'd0);
    check("rst_err_cnt", ERR_CNT, 8'd0);
    check("rst_awaddr", AWADDR, 32'd0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    exp_done = 0;

    // T1: four bursts into buffer 0
    push_words(64);
    expect_bursts(BASE, 4);
    pulse_start(64);
    wait_idle("t1");
    exp_done++;
    check("t1_frame_done", frame_done_cnt, exp_done);
    check("t1_cur_buf", CUR_BUF, 3'd1);

    // reset clears ring position
    @(posedge ACLK); #1 ARESETN = 1'b0;
    @(negedge ACLK);
    check("rst2_cur_buf", CUR_BUF, 3'd0);
    check("rst2_busy", BUSY, 1'b0);
    @(posedge ACLK); #1 ARESETN = 1'b1;

    // T2: ring rotation over three frames
    for (int f = 0; f < 3; f++) begin
      push_words(16);
      expect_bursts(t2_base[f], 1);
      pulse_start(16);
      wait_idle("t2");
      exp_done++;
      check("t2_frame_done", frame_done_cnt, exp_done);
      check("t2_cur_buf", CUR_BUF, t2_buf[f]);
    end

    // frames shorter than one burst, or with ENABLE low, are not accepted
    pulse_start(15);
    @(negedge ACLK);
    check("short_frame_busy", BUSY, 1'b0);
    ENABLE = 1'b0;
    pulse_start(16);
    @(negedge ACLK);
    check("disabled_busy", BUSY, 1'b0);
    ENABLE = 1'b1;

    // T3: AWVALID gated on FIFO level
    push_words(15);
    expect_bursts(32'h2000_1000, 1);
    pulse_start(16);
    seen_aw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (AWVALID) seen_aw = 1;
    end
    check("t3_aw_gated", seen_aw, 1'b0);
    @(posedge ACLK); #1 push_words(1);
    @(negedge ACLK);
    check("t3_aw_latency", AWVALID, 1'b0);
    @(negedge ACLK);
    check("t3_aw_raised", AWVALID, 1'b1);
    wait_idle("t3");
    exp_done++;
    check("t3_frame_done", frame_done_cnt, exp_done);
    check("t3_cur_buf", CUR_BUF, 3'd0);

    // T4: slow AWREADY, random WREADY
    aw_delay = 5; w_random = 1;
    rd0 = int'(rd_cnt); wl0 = wlast_cnt;
    push_words(16);
    expect_bursts(BASE, 1);
    pulse_start(16);
    wait_idle("t4");
    exp_done++;
    check("t4_pops", int'(rd_cnt) - rd0, 16);
    check("t4_wlast_count", wlast_cnt - wl0, 1);
    check("t4_frame_done", frame_done_cnt, exp_done);
    check("t4_cur_buf", CUR_BUF, 3'd1);
    aw_delay = 0; w_random = 0;

    // T5: ENABLE drops during burst 2 of 4; START while busy is ignored
    push_words(32);
    expect_bursts(32'h2000_1000, 2);
    hs0 = aw_hs_cnt;
    pulse_start(64);
    n = 0;
    while (aw_hs_cnt < hs0 + 1 && n < 500) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1 START = 1'b1;
    @(posedge ACLK); #1 START = 1'b0;
    while (aw_hs_cnt < hs0 + 2 && n < 500) begin @(negedge ACLK); n++; end
    check("t5_second_burst", aw_hs_cnt, hs0 + 2);
    @(posedge ACLK); #1 ENABLE = 1'b0;
    wait_idle("t5");
    repeat (10) @(negedge ACLK);
    check("t5_stays_idle", BUSY, 1'b0);
    check("t5_no_frame_done", frame_done_cnt, exp_done);
    check("t5_cur_buf", CUR_BUF, 3'd1);
    check("t5_aw_left", exp_aw_q.size(), 0);
    ENABLE = 1'b1;

    // T6: error responses on bursts 1 and 3; low FRAME_BEATS bits ignored
    push_words(64);
    expect_bursts(32'h2000_1000, 4);
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    pulse_start(69);
    wait_idle("t6");
    exp_done++;
    check("t6_frame_done", frame_done_cnt, exp_done);
    check("t6_cur_buf", CUR_BUF, 3'd0);
`ifdef CAPW_BRESP_ERR_EN
    check("t6_err_cnt", ERR_CNT, 8'd2);
`else
    check("t6_err_cnt", ERR_CNT, 8'd0);
`endif

    // final report
    check("end_aw_queue", exp_aw_q.size(), 0);
    check("end_w_queue", exp_w_q.size(), 0);
    check("end_b_queue", bresp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
